board_memory: RTL and testbench
===============================

Name: board_memory

Overview:
- Storage end of the game_logic board-change interface: accepts the board_change_addr / board_change_piece / board_change_enable writes that game_logic issues.
- Also executes atomic two-square moves and serves the board back, as a flat vector to game_logic and through a registered read port for the display path.
- Owns the initial chess layout: loads it square-by-square after reset or on a new-game request.
- Sits in chess_top between game_logic and the future VGA renderer.

Parameters:
- ADDR_W, 6, square address width; addr = {row[2:0], col[2:0]}.
- PIECE_W, 4, square encoding {color, type[2:0]}.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- new_game  in  1  one-cycle pulse; restarts the initial-layout load.
- wr_en  in  1  single-square write request (from board_change_enable).
- wr_addr  in  6  write square.
- wr_piece  in  4  value to write.
- move_en  in  1  move request: board[dst] <= board[src], board[src] <= empty.
- move_src  in  6  move source square.
- move_dst  in  6  move destination square.
- ready  out  1  high only in IDLE; requests are accepted only when high.
- init_done  out  1  high once the layout load has completed.
- rd_addr  in  6  display read address.
- rd_piece  out  4  registered read data, 1-cycle latency.
- board_flat  out  256  combinational view; square n at bits [4n+3:4n].

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RESET.
- Storage: 64 x 4-bit register array.
- FSM states: INIT, IDLE, MOVE.
- On a RESET edge:
  - state=INIT, init counter=0, rd_piece=0, init_done=0, ready=0, move hold register=0.
  - The array is not cleared by reset; INIT overwrites every square.
- INIT:
  - Each edge writes board[cnt] <= initial_piece(cnt), then cnt++.
  - With RESET deasserted before edge 1, square k is written at edge k+1.
  - After the write of square 63 (edge 64): state=IDLE, init_done=1, ready=1. Total 64 cycles.
  - wr_en and move_en are ignored in INIT and not queued.
- Initial layout; empty = 4'h0, white = color 0, black = color 1:
  - Row 7 (white back rank): R N B Q K B N R = 4,2,3,5,6,3,2,4.
  - Row 6: white pawns, 4'h1.
  - Rows 5..2: empty.
  - Row 1: black pawns, 4'h9.
  - Row 0 (black back rank): C,A,B,D,E,B,A,C.
- IDLE, request precedence: RESET > new_game > move_en > wr_en.
  - new_game: state=INIT, cnt=0, init_done=0. The edge consuming new_game performs no array write.
  - move_en: latch hold <= board[move_src]; state=MOVE; ready drops the next cycle. A wr_en in the same cycle is dropped.
  - wr_en alone: board[wr_addr] <= wr_piece at that edge; state stays IDLE.
- MOVE (exactly 1 cycle):
  - board[move_src] <= 0, then board[move_dst] <= hold. The dst write wins, so src==dst leaves the piece unchanged.
  - Then return to IDLE; ready=1 again.
  - move_src/move_dst are latched at acceptance; later input changes are ignored.
  - new_game arriving during MOVE is ignored. The MOVE completes.
- Read port: rd_piece <= board[rd_addr] every edge, in any state except a RESET edge. It returns the array contents before that edge's write (read-before-write).
- board_flat: reflects the array continuously. Partial values are visible during INIT.
- RESET mid-INIT or mid-MOVE aborts the operation and restarts INIT from square 0. A half-done move is overwritten by the layout.

Decomposition:
- Package chess_defs:
  - PIECE_NONE..PIECE_KING (3'b000..3'b110), COLOR_WHITE=0, COLOR_BLACK=1.
  - EMPTY_SQUARE=4'h0.
  - Board address width and the row/col field split.
- Sub-module board_init_rom: combinational, 6-bit addr in -> 4-bit initial piece out. It is used by INIT and is reusable by the testbench as the golden model.

Test Plan:
1. Reset load: pulse RESET 1 cycle, release. Required: ready=0 for 64 cycles, then init_done=1 and ready=1. board_flat[3:0]=4'hC, square 60 = 4'h6, square 8 = 4'h9, square 20 = 4'h0.
2. Single write: in IDLE, wr_en, wr_addr=27, wr_piece=4'h5. Required: square 27 = 4'h5 after the edge; ready stays 1. With rd_addr=27 on that same edge, rd_piece returns the old 4'h0 first, then 4'h5 one cycle later.
3. Move: move_en, src=52, dst=36. Required: ready=0 for 1 cycle; afterwards square 36 = 4'h1 and square 52 = 4'h0. A src==dst=0 move leaves square 0 at 4'hC.
4. Collision: move_en (src=57, dst=42) and wr_en (addr=10, piece=4'h3) in the same cycle. Required: the move is performed and square 10 stays 4'h9. wr_en or move_en asserted during INIT changes nothing.
5. new_game after edits: required re-INIT of 64 cycles, with every square equal to board_init_rom, including previously edited squares 27, 36 and 52.
6. RESET at INIT cycle 30, and separately during the MOVE cycle. Required: the load restarts from square 0, init_done=1 exactly 64 cycles after RESET deasserts, and the final board matches the initial layout.

Source files
------------

// File: rtl/chess_defs_pkg.sv
// Shared chess encodings: piece types, colours, square encoding and the
// board address split used by the board storage and its layout ROM.
package chess_defs;

  localparam int BOARD_ADDR_W = 6;
  localparam int SQUARE_W     = 4;
  localparam int ROW_W        = 3;
  localparam int COL_W        = 3;
  localparam int NUM_SQUARES  = 1 << BOARD_ADDR_W;

  localparam logic [2:0] PIECE_NONE   = 3'b000;
  localparam logic [2:0] PIECE_PAWN   = 3'b001;
  localparam logic [2:0] PIECE_KNIGHT = 3'b010;
  localparam logic [2:0] PIECE_BISHOP = 3'b011;
  localparam logic [2:0] PIECE_ROOK   = 3'b100;
  localparam logic [2:0] PIECE_QUEEN  = 3'b101;
  localparam logic [2:0] PIECE_KING   = 3'b110;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  localparam logic [SQUARE_W-1:0] EMPTY_SQUARE = 4'h0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_MOVE = 2'd2
  } board_state_t;

  function automatic logic [ROW_W-1:0] sq_row(input logic [BOARD_ADDR_W-1:0] addr);
    return addr[BOARD_ADDR_W-1:COL_W];
  endfunction

  function automatic logic [COL_W-1:0] sq_col(input logic [BOARD_ADDR_W-1:0] addr);
    return addr[COL_W-1:0];
  endfunction

  function automatic logic [SQUARE_W-1:0] make_piece(input logic color,
                                                     input logic [2:0] kind);
    return {color, kind};
  endfunction

endpackage

// File: rtl/board_init_rom.sv
// Combinational starting-position lookup: square address in, initial piece out.
// White occupies rows 7/6, black rows 1/0, both back ranks share column order.
module board_init_rom
  import chess_defs::*;
(
  input  logic [BOARD_ADDR_W-1:0] i_addr,
  output logic [SQUARE_W-1:0]     o_piece
);

  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic [2:0]       w_back_kind;

  assign w_row = sq_row(i_addr);
  assign w_col = sq_col(i_addr);

  always_comb begin
    w_back_kind = PIECE_NONE;
    case (w_col)
      3'd0, 3'd7: w_back_kind = PIECE_ROOK;
      3'd1, 3'd6: w_back_kind = PIECE_KNIGHT;
      3'd2, 3'd5: w_back_kind = PIECE_BISHOP;
      3'd3:       w_back_kind = PIECE_QUEEN;
      3'd4:       w_back_kind = PIECE_KING;
      default:    w_back_kind = PIECE_NONE;
    endcase
  end

  always_comb begin
    o_piece = EMPTY_SQUARE;
    case (w_row)
      3'd7:    o_piece = make_piece(COLOR_WHITE, w_back_kind);
      3'd6:    o_piece = make_piece(COLOR_WHITE, PIECE_PAWN);
      3'd1:    o_piece = make_piece(COLOR_BLACK, PIECE_PAWN);
      3'd0:    o_piece = make_piece(COLOR_BLACK, w_back_kind);
      default: o_piece = EMPTY_SQUARE;
    endcase
  end

endmodule

// File: rtl/board_memory.sv
// 64-square board store: loads the starting layout, takes single-square
// writes and atomic two-square moves, and serves a flat view plus a read port.
module board_memory
  import chess_defs::*;
#(
  parameter int ADDR_W  = BOARD_ADDR_W,
  parameter int PIECE_W = SQUARE_W
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              new_game,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [PIECE_W-1:0]                wr_piece,
  input  logic                              move_en,
  input  logic [ADDR_W-1:0]                 move_src,
  input  logic [ADDR_W-1:0]                 move_dst,
  output logic                              ready,
  output logic                              init_done,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [PIECE_W-1:0]                rd_piece,
  output logic [(1<<ADDR_W)*PIECE_W-1:0]    board_flat
);

  localparam int NSQ = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_SQ = ADDR_W'(NSQ - 1);

  board_state_t       r_state;
  board_state_t       w_state_nxt;

  logic [PIECE_W-1:0] r_board [NSQ];
  logic [ADDR_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [PIECE_W-1:0] r_hold;
  logic [PIECE_W-1:0] r_rd_piece;
  logic               r_init_done;

  logic               w_init_wr;
  logic               w_init_last;
  logic               w_new_game_acc;
  logic               w_move_acc;
  logic               w_wr_acc;
  logic               w_move_exec;
  logic [PIECE_W-1:0] w_rom_piece;

  board_init_rom u_rom (
    .i_addr  (r_cnt),
    .o_piece (w_rom_piece)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_wr      = 1'b0;
    w_init_last    = 1'b0;
    w_new_game_acc = 1'b0;
    w_move_acc     = 1'b0;
    w_wr_acc       = 1'b0;
    w_move_exec    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_wr   = 1'b1;
        w_init_last = (r_cnt == LAST_SQ);
        if (w_init_last) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // new_game outranks a move, a move outranks a plain write
        if (new_game) begin
          w_new_game_acc = 1'b1;
          w_state_nxt    = ST_INIT;
        end else if (move_en) begin
          w_move_acc  = 1'b1;
          w_state_nxt = ST_MOVE;
        end else if (wr_en) begin
          w_wr_acc = 1'b1;
        end
      end
      ST_MOVE: begin
        w_move_exec = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_hold      <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_rd_piece  <= '0;
    end else begin
      r_rd_piece <= r_board[rd_addr];
      if (w_new_game_acc)  r_cnt <= '0;
      else if (w_init_wr)  r_cnt <= r_cnt + ADDR_W'(1);
      if (w_new_game_acc)  r_init_done <= 1'b0;
      else if (w_init_last) r_init_done <= 1'b1;
      if (w_move_acc) begin
        r_hold <= r_board[move_src];
        r_src  <= move_src;
        r_dst  <= move_dst;
      end
    end
  end

  // The array has no reset: INIT rewrites every square afterwards.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (w_init_wr) r_board[r_cnt]   <= w_rom_piece;
      if (w_wr_acc)  r_board[wr_addr] <= wr_piece;
      if (w_move_exec) begin
        r_board[r_src] <= EMPTY_SQUARE;
        r_board[r_dst] <= r_hold;
      end
    end
  end

  for (genvar g = 0; g < NSQ; g++) begin : g_flat
    assign board_flat[g*PIECE_W +: PIECE_W] = r_board[g];
  end

  assign ready     = (r_state == ST_IDLE);
  assign init_done = r_init_done;
  assign rd_piece  = r_rd_piece;

endmodule

// File: tb/tb_board_memory.sv
// Bench for board_memory: a per-square behavioural board model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_board_memory;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         new_game;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [3:0]   wr_piece;
  logic         move_en;
  logic [5:0]   move_src;
  logic [5:0]   move_dst;
  logic [5:0]   rd_addr;
  wire          ready;
  wire          init_done;
  wire  [3:0]   rd_piece;
  wire  [255:0] board_flat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  board_memory dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .new_game   (new_game),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_piece   (wr_piece),
    .move_en    (move_en),
    .move_src   (move_src),
    .move_dst   (move_dst),
    .ready      (ready),
    .init_done  (init_done),
    .rd_addr    (rd_addr),
    .rd_piece   (rd_piece),
    .board_flat (board_flat)
  );

  // Starting position written out from the rules of chess.
  function automatic logic [3:0] layout(input int sq);
    int row;
    int col;
    int back;
    row = sq / 8;
    col = sq % 8;
    case (col)
      0, 7:    back = 4;
      1, 6:    back = 2;
      2, 5:    back = 3;
      3:       back = 5;
      default: back = 6;
    endcase
    case (row)
      7:       return 4'(back);
      6:       return 4'h1;
      1:       return 4'h9;
      0:       return 4'(8 + back);
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [255:0] layout_vec();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[i*4 +: 4] = layout(i);
    return v;
  endfunction

  function automatic logic [3:0] sq(input int n);
    return board_flat[n*4 +: 4];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 = loading, 1 = idle, 2 = move in progress.
  logic [3:0] m_board [64];
  bit         m_known [64];
  int         m_mode = 0;
  int         m_cnt  = 0;
  int         m_src  = 0;
  int         m_dst  = 0;
  logic [3:0] m_hold = 4'h0;
  logic [3:0] m_rd   = 4'h0;
  bit         m_rd_known = 1'b0;
  bit         m_done  = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_valid    = 1'b1;
      m_mode     = 0;
      m_cnt      = 0;
      m_rd       = 4'h0;
      m_rd_known = 1'b1;
      m_done     = 1'b0;
      m_hold     = 4'h0;
    end else if (m_valid) begin
      m_rd       = m_board[rd_addr];
      m_rd_known = m_known[rd_addr];
      case (m_mode)
        0: begin
          m_board[m_cnt] = layout(m_cnt);
          m_known[m_cnt] = 1'b1;
          if (m_cnt == 63) begin
            m_mode = 1;
            m_done = 1'b1;
          end
          m_cnt = (m_cnt + 1) % 64;
        end
        1: begin
          if (new_game) begin
            m_mode = 0;
            m_cnt  = 0;
            m_done = 1'b0;
          end else if (move_en) begin
            m_hold = m_board[move_src];
            m_src  = move_src;
            m_dst  = move_dst;
            m_mode = 2;
          end else if (wr_en) begin
            m_board[wr_addr] = wr_piece;
            m_known[wr_addr] = 1'b1;
          end
        end
        default: begin
          m_board[m_src] = 4'h0;
          m_known[m_src] = 1'b1;
          m_board[m_dst] = m_hold;
          m_known[m_dst] = 1'b1;
          m_mode = 1;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    logic [255:0] exp_v;
    logic [255:0] mask_v;
    if (m_valid) begin
      exp_v  = '0;
      mask_v = '0;
      for (int i = 0; i < 64; i++) begin
        if (m_known[i]) begin
          exp_v[i*4 +: 4]  = m_board[i];
          mask_v[i*4 +: 4] = 4'hF;
        end
      end
      check("model_ready", ready, m_mode == 1);
      check("model_init_done", init_done, m_done);
      if (m_rd_known) check("model_rd_piece", rd_piece, m_rd);
      check("model_board_flat", board_flat & mask_v, exp_v & mask_v);
    end
  end

  task automatic wait_init(input int expect_cycles);
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      n++;
      if (init_done === 1'b1) break;
    end
    check("init_cycles", n, expect_cycles);
  endtask

  initial begin
    RESET = 1'b1; new_game = 1'b0; wr_en = 1'b0; move_en = 1'b0;
    wr_addr = '0; wr_piece = '0; move_src = '0; move_dst = '0; rd_addr = '0;

    // Reset load
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    wait_init(64);
    check("ready_after_init", ready, 1'b1);
    check("sq0", sq(0), 4'hC);
    check("sq60", sq(60), 4'h6);
    check("sq8", sq(8), 4'h9);
    check("sq20", sq(20), 4'h0);

    // Single write, read-before-write on the same edge
    wr_en = 1'b1; wr_addr = 6'd27; wr_piece = 4'h5; rd_addr = 6'd27;
    @(negedge CLK);
    wr_en = 1'b0;
    check("wr_rd_old", rd_piece, 4'h0);
    check("wr_sq27", sq(27), 4'h5);
    check("wr_ready", ready, 1'b1);
    @(negedge CLK);
    check("wr_rd_new", rd_piece, 4'h5);

    // Move, with inputs changing after acceptance
    move_en = 1'b1; move_src = 6'd52; move_dst = 6'd36;
    @(negedge CLK);
    move_en = 1'b0; move_src = 6'd0; move_dst = 6'd1;
    check("move_ready_low", ready, 1'b0);
    @(negedge CLK);
    check("move_ready_back", ready, 1'b1);
    check("move_sq36", sq(36), 4'h1);
    check("move_sq52", sq(52), 4'h0);
    check("move_sq1_untouched", sq(1), 4'hA);
    move_en = 1'b1; move_src = 6'd0; move_dst = 6'd0;
    @(negedge CLK);
    move_en = 1'b0;
    @(negedge CLK);
    check("self_move_sq0", sq(0), 4'hC);

    // Move and write together: move wins, write dropped
    move_en = 1'b1; move_src = 6'd57; move_dst = 6'd42;
    wr_en = 1'b1; wr_addr = 6'd10; wr_piece = 4'h3;
    @(negedge CLK);
    move_en = 1'b0; wr_en = 1'b0;
    @(negedge CLK);
    check("coll_sq10", sq(10), 4'h9);
    check("coll_sq42", sq(42), 4'h2);
    check("coll_sq57", sq(57), 4'h0);

    // new_game, with requests asserted during the load
    new_game = 1'b1;
    @(negedge CLK);
    new_game = 1'b0;
    check("ng_init_done_low", init_done, 1'b0);
    wr_en = 1'b1; wr_addr = 6'd20; wr_piece = 4'hF;
    move_en = 1'b1; move_src = 6'd0; move_dst = 6'd20;
    repeat (10) @(negedge CLK);
    wr_en = 1'b0; move_en = 1'b0;
    wait_init(54);
    check("ng_board", board_flat, layout_vec());
    check("ng_sq27", sq(27), 4'h0);
    check("ng_sq36", sq(36), 4'h0);
    check("ng_sq52", sq(52), 4'h1);
    check("ng_sq20", sq(20), 4'h0);

    // RESET part-way through a load
    new_game = 1'b1;
    @(negedge CLK);
    new_game = 1'b0;
    repeat (30) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_init_rd_zero", rd_piece, 4'h0);
    wait_init(64);
    check("rst_init_board", board_flat, layout_vec());

    // RESET during the MOVE cycle
    move_en = 1'b1; move_src = 6'd48; move_dst = 6'd40;
    @(negedge CLK);
    move_en = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    wait_init(64);
    check("rst_move_board", board_flat, layout_vec());
    check("rst_move_ready", ready, 1'b1);

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
